// File: rtl/au_issue_ctrl_pkg.sv
// Shared definitions for the AU issue controller: architecture widths,
// AU opcodes, 3-bit FSM state encodings and an opcode classifier.
// Optional feature macro used by the controller: AU_DIV0_CHECK_EN.
package au_issue_ctrl_pkg;

  // System architecture widths
  localparam int DATA_WIDTH   = 16;
  localparam int OPCODE_WIDTH = 3;

  // Default AU latency in cycles from strobe fall to au_out capture
  localparam int AU_LATENCY_DEFAULT = 1;

  // AU opcodes
  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MULT = 3'd3,
    OP_DIV  = 3'd4
  } au_op_e;

  // FSM state encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Result returned for a rejected divide-by-zero or unknown opcode
  localparam logic [DATA_WIDTH-1:0] DIV0_RESULT = '1;

  // True for opcodes that are actually issued to the AU
  function automatic logic is_au_op(input logic [OPCODE_WIDTH-1:0] m);
    return (m == OP_ADD) || (m == OP_SUB) || (m == OP_MULT) || (m == OP_DIV);
  endfunction

endpackage

// File: rtl/au_issue_ctrl_wait_counter.sv
// Down-counter that times the AU latency window: loaded while the strobe
// is high, decremented through WAIT, done on the last WAIT cycle.
import au_issue_ctrl_pkg::*;

module au_wait_counter #(
  parameter int LATENCY = AU_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  logic [CW-1:0] cnt;

  // Load the latency on the strobe cycle, count down while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LATENCY);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = dec && (cnt == CW'(1));

endmodule

// File: rtl/au_issue_ctrl.sv
// AU issue controller: takes one arithmetic command at a time, sets up the
// AU operands, fires a one-cycle enable strobe, waits the AU latency and
// returns the captured result with the command tag.
// Optional feature: define AU_DIV0_CHECK_EN to add rsp_err and reject
// divide-by-zero / unknown opcodes without touching the AU.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once raised, rsp_valid and its rsp_data/rsp_tag stay constant
// until that transfer; the command side is only ready in IDLE.
import au_issue_ctrl_pkg::*;

module au_issue_ctrl #(
  parameter int DATA_W     = DATA_WIDTH,
  parameter int OP_W       = OPCODE_WIDTH,
  parameter int TAG_W      = 4,
  parameter int AU_LATENCY = AU_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_mode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              au_op_enable,
  output logic [OP_W-1:0]   au_mode,
  output logic [DATA_W-1:0] au_in_1,
  output logic [DATA_W-1:0] au_in_2,
  input  logic [DATA_W-1:0] au_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
`ifdef AU_DIV0_CHECK_EN
  output logic              rsp_err,
`endif
  output logic [15:0]       op_count,
  output logic [2:0]        dbg_state
);

  logic [2:0]       state;
  logic [TAG_W-1:0] tag_q;
  logic             wait_done;
  logic             issue_ok;
`ifdef AU_DIV0_CHECK_EN
  logic             reject;
`endif

  assign dbg_state = state;

  // Decide at acceptance whether the command goes to the AU
`ifdef AU_DIV0_CHECK_EN
  assign reject   = !is_au_op(OPCODE_WIDTH'(cmd_mode)) ||
                    ((OPCODE_WIDTH'(cmd_mode) == OP_DIV) && (cmd_b == '0));
  assign issue_ok = !reject;
`else
  assign issue_ok = is_au_op(OPCODE_WIDTH'(cmd_mode));
`endif

  au_wait_counter #(.LATENCY(AU_LATENCY)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == S_STROBE),
    .dec   (state == S_WAIT),
    .done  (wait_done)
  );

  // Main sequencer; every output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      au_op_enable <= 1'b0;
      au_mode      <= '0;
      au_in_1      <= '0;
      au_in_2      <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_tag      <= '0;
      tag_q        <= '0;
      op_count     <= '0;
`ifdef AU_DIV0_CHECK_EN
      rsp_err      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            tag_q     <= cmd_tag;
            if (issue_ok) begin
              // Operand registers double as the command latches
              au_mode <= cmd_mode;
              au_in_1 <= cmd_a;
              au_in_2 <= cmd_b;
              state   <= S_SETUP;
            end else begin
              // Skipped op: respond next cycle, AU inputs untouched
              rsp_valid <= 1'b1;
              rsp_tag   <= cmd_tag;
`ifdef AU_DIV0_CHECK_EN
              rsp_data  <= {DATA_W{1'b1}};
              rsp_err   <= 1'b1;
`else
              rsp_data  <= '0;
`endif
              state     <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          au_op_enable <= 1'b1;
          state        <= S_STROBE;
        end
        S_STROBE: begin
          au_op_enable <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= au_out;
            rsp_tag   <= tag_q;
`ifdef AU_DIV0_CHECK_EN
            rsp_err   <= 1'b0;
`endif
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state        <= S_IDLE;
          cmd_ready    <= 1'b1;
          au_op_enable <= 1'b0;
          rsp_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule
